// File: rtl/psum_pad.sv
// Partial-sum scratchpad: SumStage read/write port during COMP, plus fill (LOAD)
// and drain (DRAIN) streams toward the array, sequenced by a small command FSM.
module psum_pad #(
  parameter int DWd   = 16,
  parameter int Depth = 16,
  parameter int AWd   = $clog2(Depth)
) (
  input  logic                  i_clk,
  input  logic                  i_rst,
  input  logic                  i_cmd_valid,
  input  logic [1:0]            i_cmd,
  input  logic [AWd:0]          i_cmd_len,
  output logic                  o_busy,
  input  logic                  i_comp_done,
  input  logic                  i_stall,
  input  logic                  i_rd_en,
  input  logic [AWd-1:0]        i_rd_addr,
  output logic signed [DWd-1:0] o_psum,
  output logic                  o_rd_valid,
  input  logic                  i_wr_en,
  input  logic [AWd-1:0]        i_wr_addr,
  input  logic signed [DWd-1:0] i_psum,
  input  logic                  i_ld_valid,
  output logic                  o_ld_ready,
  input  logic [DWd-1:0]        i_ld_data,
  output logic                  o_dr_valid,
  input  logic                  i_dr_ready,
  output logic signed [DWd-1:0] o_dr_data,
  output logic                  o_err
);

  localparam logic [1:0]   CMD_LOAD  = 2'd0;
  localparam logic [1:0]   CMD_COMP  = 2'd1;
  localparam logic [1:0]   CMD_DRAIN = 2'd2;
  localparam logic [1:0]   CMD_RSVD  = 2'd3;
  localparam logic [AWd:0] DEPTH_L   = (AWd+1)'(Depth);

  typedef enum logic [1:0] {S_IDLE, S_LOAD, S_COMP, S_DRAIN} state_e;

  state_e                state_q;
  logic [AWd:0]          len_q;
  logic [AWd:0]          ld_cnt_q;
  logic [AWd:0]          rd_cnt_q;
  logic signed [DWd-1:0] psum_q;
  logic                  rd_valid_q;
  logic signed [DWd-1:0] dr_data_q;
  logic                  dr_valid_q;
  logic                  err_q;

  logic [DWd-1:0] mem [Depth];

  logic           ld_hs, comp_rd, comp_wr, dr_free, dr_load, dr_done;
  logic           cmd_ok, len_over, err_set;
  logic [AWd:0]   len_clamp, ld_cnt_d;
  logic           mem_we;
  logic [AWd-1:0] mem_waddr;
  logic [DWd-1:0] mem_wdata;

  assign ld_hs    = (state_q == S_LOAD) && i_ld_valid && (ld_cnt_q < len_q);
  assign comp_rd  = (state_q == S_COMP) && i_rd_en && !i_stall;
  assign comp_wr  = (state_q == S_COMP) && i_wr_en && !i_stall;
  // Output-register drain: refill whenever the register is empty or being taken.
  assign dr_free  = !dr_valid_q || i_dr_ready;
  assign dr_load  = (state_q == S_DRAIN) && dr_free && (rd_cnt_q < len_q);
  assign dr_done  = (state_q == S_DRAIN) && dr_free && (rd_cnt_q == len_q);
  assign ld_cnt_d = ld_cnt_q + {{AWd{1'b0}}, ld_hs};

  assign cmd_ok    = (state_q == S_IDLE) && i_cmd_valid && (i_cmd != CMD_RSVD);
  assign len_over  = i_cmd_len > DEPTH_L;
  assign len_clamp = len_over ? DEPTH_L : i_cmd_len;
  assign err_set   = (i_cmd_valid && ((state_q != S_IDLE) || (i_cmd == CMD_RSVD)))
                   || (cmd_ok && (i_cmd != CMD_COMP) && len_over)
                   || ((i_rd_en || i_wr_en) && (state_q != S_COMP));

  always_comb begin
    mem_we    = 1'b0;
    mem_waddr = i_wr_addr;
    mem_wdata = i_psum;
    if (ld_hs) begin
      mem_we    = 1'b1;
      mem_waddr = ld_cnt_q[AWd-1:0];
      mem_wdata = i_ld_data;
    end else if (comp_wr) begin
      mem_we = 1'b1;
    end
  end

  always_ff @(posedge i_clk) begin
    if (mem_we) mem[mem_waddr] <= mem_wdata;
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      state_q    <= S_IDLE;
      len_q      <= '0;
      ld_cnt_q   <= '0;
      rd_cnt_q   <= '0;
      psum_q     <= '0;
      rd_valid_q <= 1'b0;
      dr_data_q  <= '0;
      dr_valid_q <= 1'b0;
      err_q      <= 1'b0;
    end else begin
      if (err_set) err_q <= 1'b1;

      // Same-address write in the read cycle is forwarded so SumStage sees the new psum.
      if (comp_rd) begin
        rd_valid_q <= 1'b1;
        psum_q     <= (comp_wr && (i_wr_addr == i_rd_addr)) ? i_psum : mem[i_rd_addr];
      end else if (!((state_q == S_COMP) && i_stall)) begin
        rd_valid_q <= 1'b0;
      end

      if (dr_load) begin
        dr_data_q  <= mem[rd_cnt_q[AWd-1:0]];
        dr_valid_q <= 1'b1;
        rd_cnt_q   <= rd_cnt_q + 1'b1;
      end else if (dr_valid_q && i_dr_ready) begin
        dr_valid_q <= 1'b0;
      end

      ld_cnt_q <= ld_cnt_d;

      case (state_q)
        S_IDLE: begin
          if (cmd_ok) begin
            len_q    <= len_clamp;
            ld_cnt_q <= '0;
            rd_cnt_q <= '0;
            case (i_cmd)
              CMD_LOAD:  state_q <= S_LOAD;
              CMD_COMP:  state_q <= S_COMP;
              default:   state_q <= S_DRAIN;
            endcase
          end
        end
        S_LOAD:  if (ld_cnt_d == len_q) state_q <= S_IDLE;
        S_COMP:  if (i_comp_done) state_q <= S_IDLE;
        S_DRAIN: if (dr_done) state_q <= S_IDLE;
        default: state_q <= S_IDLE;
      endcase
    end
  end

  assign o_busy     = (state_q != S_IDLE);
  assign o_ld_ready = (state_q == S_LOAD) && (ld_cnt_q < len_q);
  assign o_psum     = psum_q;
  assign o_rd_valid = rd_valid_q;
  assign o_dr_valid = dr_valid_q;
  assign o_dr_data  = dr_data_q;
  assign o_err      = err_q;

endmodule

// File: tb/tb_psum_pad.sv
// Randomized bench for psum_pad: a word-array reference of the scratchpad predicts
// fill/drain streams, COMP reads (with forwarding and stall hold) and error flags.
module tb_psum_pad;

  logic               i_clk = 1'b0;
  logic               i_rst, i_cmd_valid, i_comp_done, i_stall;
  logic [1:0]         i_cmd;
  logic [4:0]         i_cmd_len;
  logic               o_busy;
  logic               i_rd_en, i_wr_en;
  logic [3:0]         i_rd_addr, i_wr_addr;
  logic signed [15:0] o_psum, i_psum, o_dr_data;
  logic               o_rd_valid;
  logic               i_ld_valid, o_ld_ready, o_dr_valid, i_dr_ready, o_err;
  logic [15:0]        i_ld_data;

  int total = 0;
  int bad   = 0;

  logic [15:0] ref_mem [16];
  logic [15:0] ld_buf  [16];

  always #5 i_clk = ~i_clk;

  psum_pad #(.DWd(16), .Depth(16)) dut (
    .i_clk(i_clk), .i_rst(i_rst), .i_cmd_valid(i_cmd_valid), .i_cmd(i_cmd),
    .i_cmd_len(i_cmd_len), .o_busy(o_busy), .i_comp_done(i_comp_done), .i_stall(i_stall),
    .i_rd_en(i_rd_en), .i_rd_addr(i_rd_addr), .o_psum(o_psum), .o_rd_valid(o_rd_valid),
    .i_wr_en(i_wr_en), .i_wr_addr(i_wr_addr), .i_psum(i_psum),
    .i_ld_valid(i_ld_valid), .o_ld_ready(o_ld_ready), .i_ld_data(i_ld_data),
    .o_dr_valid(o_dr_valid), .i_dr_ready(i_dr_ready), .o_dr_data(o_dr_data), .o_err(o_err)
  );

  task automatic tick();
    @(posedge i_clk);
    #1;
  endtask

  task automatic do_reset();
    i_rst = 1'b1;
    i_cmd_valid = 0; i_cmd = 0; i_cmd_len = 0; i_comp_done = 0; i_stall = 0;
    i_rd_en = 0; i_wr_en = 0; i_rd_addr = 0; i_wr_addr = 0; i_psum = 0;
    i_ld_valid = 0; i_ld_data = 0; i_dr_ready = 0;
    tick();
    tick();
    i_rst = 1'b0;
  endtask

  task automatic send_cmd(input logic [1:0] c, input int len);
    i_cmd_valid = 1'b1;
    i_cmd       = c;
    i_cmd_len   = 5'(len);
    tick();
    i_cmd_valid = 1'b0;
  endtask

  // Fill from ld_buf with random valid gaps; checks ready while words remain.
  task automatic do_load(input int len);
    int n, idx, cyc;
    logic v;
    n = (len > 16) ? 16 : len;
    send_cmd(2'd0, len);
    idx = 0; cyc = 0;
    while (idx < n && cyc < 200) begin
      v = ($urandom_range(0, 3) != 0);
      i_ld_valid = v;
      i_ld_data  = ld_buf[idx];
      total++;
      if (o_ld_ready !== 1'b1) begin
        bad++; $display("FAIL load_ready word=%0d got=%b exp=1", idx, o_ld_ready);
      end
      tick();
      if (v) begin ref_mem[idx] = ld_buf[idx]; idx++; end
      cyc++;
    end
    i_ld_valid = 1'b0;
    total++;
    if (o_ld_ready !== 1'b0 || o_busy !== 1'b0) begin
      bad++; $display("FAIL load_end ready=%b busy=%b exp 0/0 words=%0d", o_ld_ready, o_busy, idx);
    end
  endtask

  // mode 0: ready tied 1, mode 1: ready 1,0,0,1,1 then 1, mode 2: random ready.
  task automatic do_drain(input int len, input int mode, input int stop_after);
    int n, idx, cyc, first_hs, last_hs;
    logic r, prev_hold;
    logic [15:0] held_d;
    logic [4:0] pat;
    pat = 5'b11001;
    n = (len > 16) ? 16 : len;
    send_cmd(2'd2, len);
    idx = 0; cyc = 0; first_hs = -1; last_hs = -1; prev_hold = 0; held_d = 0;
    while (idx < n && cyc < 300) begin
      if (mode == 0) r = 1'b1;
      else if (mode == 1) r = (cyc < 5) ? pat[cyc] : 1'b1;
      else r = 1'(($urandom_range(0, 1)));
      i_dr_ready = r;
      if (prev_hold) begin
        total++;
        if (o_dr_valid !== 1'b1 || o_dr_data !== held_d) begin
          bad++; $display("FAIL drain_hold cyc=%0d valid=%b data=%h exp 1/%h", cyc, o_dr_valid, o_dr_data, held_d);
        end
      end
      if (o_dr_valid && r) begin
        total++;
        if (o_dr_data !== ref_mem[idx]) begin
          bad++; $display("FAIL drain_data word=%0d got=%h exp=%h", idx, o_dr_data, ref_mem[idx]);
        end
        if (first_hs < 0) first_hs = cyc;
        last_hs = cyc;
        idx++;
      end
      prev_hold = o_dr_valid && !r;
      held_d    = o_dr_data;
      tick();
      cyc++;
      if (stop_after > 0 && idx == stop_after) break;
    end
    if (stop_after == 0) begin
      i_dr_ready = 1'b0;
      total++;
      if (idx != n) begin
        bad++; $display("FAIL drain_count got=%0d exp=%0d", idx, n);
      end
      total++;
      if (o_busy !== 1'b0 || o_dr_valid !== 1'b0) begin
        bad++; $display("FAIL drain_end busy=%b valid=%b exp 0/0", o_busy, o_dr_valid);
      end
      if (mode == 0 && n > 0) begin
        total++;
        if (first_hs != 1 || last_hs - first_hs != n - 1) begin
          bad++; $display("FAIL drain_rate first=%0d last=%0d exp first=1 span=%0d", first_hs, last_hs, n - 1);
        end
      end
    end
  endtask

  task automatic test_reset();
    do_reset();
    total++;
    if (o_busy !== 0 || o_rd_valid !== 0 || o_ld_ready !== 0 || o_dr_valid !== 0 || o_err !== 0) begin
      bad++; $display("FAIL reset_flags busy=%b rv=%b ldr=%b drv=%b err=%b exp all 0",
                      o_busy, o_rd_valid, o_ld_ready, o_dr_valid, o_err);
    end
    total++;
    if (o_psum !== 16'h0 || o_dr_data !== 16'h0) begin
      bad++; $display("FAIL reset_data psum=%h dr=%h exp 0/0", o_psum, o_dr_data);
    end
  endtask

  task automatic test_load_drain();
    ld_buf[0] = 16'h0010; ld_buf[1] = 16'hFFF0; ld_buf[2] = 16'h7FFF; ld_buf[3] = 16'h8000;
    do_load(4);
    do_drain(4, 0, 0);
    for (int k = 0; k < 3; k++) begin
      int len;
      len = $urandom_range(1, 16);
      for (int j = 0; j < 16; j++) ld_buf[j] = 16'($urandom);
      do_load(len);
      do_drain(len, 2, 0);
    end
    total++;
    if (o_err !== 1'b0) begin
      bad++; $display("FAIL load_drain_err got=%b exp=0", o_err);
    end
  endtask

  task automatic test_comp();
    logic exp_rv, rd, wr, st;
    logic [15:0] exp_psum, wd;
    logic [3:0] ra, wa;
    send_cmd(2'd1, 0);
    // directed: write then read addr3, then same-cycle write/read on addr5
    i_wr_en = 1; i_wr_addr = 4'd3; i_psum = 16'h1234;
    tick(); ref_mem[3] = 16'h1234;
    i_wr_en = 0; i_rd_en = 1; i_rd_addr = 4'd3;
    tick();
    total++;
    if (o_rd_valid !== 1'b1 || o_psum !== 16'h1234) begin
      bad++; $display("FAIL comp_rd3 valid=%b psum=%h exp 1/1234", o_rd_valid, o_psum);
    end
    i_rd_en = 1; i_rd_addr = 4'd5; i_wr_en = 1; i_wr_addr = 4'd5; i_psum = 16'h5555;
    tick(); ref_mem[5] = 16'h5555;
    total++;
    if (o_rd_valid !== 1'b1 || o_psum !== 16'h5555) begin
      bad++; $display("FAIL comp_bypass valid=%b psum=%h exp 1/5555", o_rd_valid, o_psum);
    end
    i_rd_en = 0; i_wr_en = 0;
    tick();
    total++;
    if (o_rd_valid !== 1'b0) begin
      bad++; $display("FAIL comp_pulse valid=%b exp=0", o_rd_valid);
    end
    // random traffic over a few addresses so forwarding and stalls collide often
    exp_rv = 0; exp_psum = 0;
    for (int c = 0; c < 60; c++) begin
      rd = 1'($urandom_range(0, 1)); wr = 1'($urandom_range(0, 1));
      st = ($urandom_range(0, 3) == 0);
      ra = 4'($urandom_range(0, 3)); wa = 4'($urandom_range(0, 3)); wd = 16'($urandom);
      i_rd_en = rd; i_wr_en = wr; i_stall = st; i_rd_addr = ra; i_wr_addr = wa; i_psum = wd;
      tick();
      if (!st && rd) begin
        exp_rv = 1;
        exp_psum = (wr && wa == ra) ? wd : ref_mem[ra];
      end else if (!st) begin
        exp_rv = 0;
      end
      if (!st && wr) ref_mem[wa] = wd;
      total++;
      if (o_rd_valid !== exp_rv || (exp_rv && o_psum !== exp_psum)) begin
        bad++; $display("FAIL comp_rand cyc=%0d valid=%b psum=%h exp %b/%h", c, o_rd_valid, o_psum, exp_rv, exp_psum);
      end
    end
    i_stall = 0; i_wr_en = 0;
    i_rd_en = 1; i_rd_addr = 4'd1; i_comp_done = 1;
    tick();
    i_rd_en = 0; i_comp_done = 0;
    total++;
    if (o_busy !== 1'b0 || o_rd_valid !== 1'b1 || o_psum !== ref_mem[1]) begin
      bad++; $display("FAIL comp_done busy=%b valid=%b psum=%h exp 0/1/%h", o_busy, o_rd_valid, o_psum, ref_mem[1]);
    end
    tick();
    total++;
    if (o_rd_valid !== 1'b0 || o_err !== 1'b0) begin
      bad++; $display("FAIL comp_exit valid=%b err=%b exp 0/0", o_rd_valid, o_err);
    end
    do_drain(16, 2, 0);
  endtask

  task automatic test_stall();
    send_cmd(2'd1, 0);
    i_wr_en = 1; i_wr_addr = 4'd2; i_psum = 16'h2222;
    tick(); ref_mem[2] = 16'h2222;
    i_wr_en = 0; i_rd_en = 1; i_rd_addr = 4'd2;
    tick();
    i_stall = 1; i_wr_en = 1; i_psum = 16'h9999;
    tick(); tick();
    total++;
    if (o_rd_valid !== 1'b1 || o_psum !== 16'h2222) begin
      bad++; $display("FAIL stall_hold valid=%b psum=%h exp 1/2222", o_rd_valid, o_psum);
    end
    i_stall = 0; i_wr_en = 0;
    tick();
    total++;
    if (o_rd_valid !== 1'b1 || o_psum !== 16'h2222) begin
      bad++; $display("FAIL stall_nowrite valid=%b psum=%h exp 1/2222", o_rd_valid, o_psum);
    end
    i_wr_en = 1;
    tick(); ref_mem[2] = 16'h9999;
    i_wr_en = 0; i_rd_en = 0; i_comp_done = 1;
    tick();
    i_comp_done = 0;
    total++;
    if (o_psum !== 16'h9999 || o_busy !== 1'b0) begin
      bad++; $display("FAIL stall_release psum=%h busy=%b exp 9999/0", o_psum, o_busy);
    end
  endtask

  task automatic test_err();
    do_reset();
    i_rd_en = 1; tick(); i_rd_en = 0;
    tick();
    total++;
    if (o_err !== 1'b1) begin bad++; $display("FAIL err_rd_idle got=%b exp=1", o_err); end
    do_reset();
    i_wr_en = 1; tick(); i_wr_en = 0;
    total++;
    if (o_err !== 1'b1) begin bad++; $display("FAIL err_wr_idle got=%b exp=1", o_err); end
    do_reset();
    send_cmd(2'd3, 0);
    total++;
    if (o_err !== 1'b1 || o_busy !== 1'b0) begin
      bad++; $display("FAIL err_rsvd err=%b busy=%b exp 1/0", o_err, o_busy);
    end
    do_reset();
    ld_buf[0] = 16'hA5A5; ld_buf[1] = 16'h5A5A;
    send_cmd(2'd0, 2);
    send_cmd(2'd2, 1);
    total++;
    if (o_err !== 1'b1 || o_busy !== 1'b1 || o_ld_ready !== 1'b1) begin
      bad++; $display("FAIL err_cmd_busy err=%b busy=%b ldr=%b exp 1/1/1", o_err, o_busy, o_ld_ready);
    end
    i_ld_valid = 1; i_ld_data = ld_buf[0]; tick(); ref_mem[0] = ld_buf[0];
    i_ld_data = ld_buf[1]; tick(); ref_mem[1] = ld_buf[1];
    i_ld_valid = 0;
    total++;
    if (o_busy !== 1'b0 || o_err !== 1'b1) begin
      bad++; $display("FAIL err_sticky busy=%b err=%b exp 0/1", o_busy, o_err);
    end
    do_reset();
    for (int j = 0; j < 16; j++) ld_buf[j] = 16'($urandom);
    do_load(20);
    total++;
    if (o_err !== 1'b1) begin bad++; $display("FAIL err_len_clamp got=%b exp=1", o_err); end
    do_reset();
    send_cmd(2'd0, 0);
    total++;
    if (o_busy !== 1'b1 || o_ld_ready !== 1'b0) begin
      bad++; $display("FAIL len0_enter busy=%b ldr=%b exp 1/0", o_busy, o_ld_ready);
    end
    tick();
    total++;
    if (o_busy !== 1'b0 || o_err !== 1'b0) begin
      bad++; $display("FAIL len0_exit busy=%b err=%b exp 0/0", o_busy, o_err);
    end
  endtask

  task automatic test_reset_mid_drain();
    for (int j = 0; j < 4; j++) ld_buf[j] = 16'($urandom);
    do_load(4);
    do_drain(4, 0, 2);
    i_rst = 1;
    tick();
    i_rst = 0; i_dr_ready = 0;
    total++;
    if (o_busy !== 1'b0 || o_dr_valid !== 1'b0 || o_err !== 1'b0 || o_dr_data !== 16'h0) begin
      bad++; $display("FAIL rst_mid busy=%b drv=%b err=%b dr=%h exp 0/0/0/0", o_busy, o_dr_valid, o_err, o_dr_data);
    end
    send_cmd(2'd0, 1);
    total++;
    if (o_busy !== 1'b1 || o_ld_ready !== 1'b1) begin
      bad++; $display("FAIL rst_newcmd busy=%b ldr=%b exp 1/1", o_busy, o_ld_ready);
    end
    i_ld_valid = 1; i_ld_data = 16'hBEEF;
    tick(); ref_mem[0] = 16'hBEEF;
    i_ld_valid = 0;
    total++;
    if (o_busy !== 1'b0) begin bad++; $display("FAIL rst_newcmd_end busy=%b exp=0", o_busy); end
    do_drain(4, 1, 0);
  endtask

  task automatic test_drain_toggle();
    for (int j = 0; j < 3; j++) ld_buf[j] = 16'($urandom);
    do_load(3);
    do_drain(3, 1, 0);
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog timeout total=%0d bad=%0d", total, bad);
    $fatal(1);
  end

  initial begin
    test_reset();
    test_load_drain();
    test_comp();
    test_stall();
    test_drain_toggle();
    test_err();
    test_reset_mid_drain();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/psum_pad.md
Name: psum_pad

Overview:
- Partial-sum scratchpad inside the PE; the storage end of the SumStage psum interface.
- SumStage reads a stored psum on its first pixel and writes the updated psum back on its last pixel. This block serves both accesses.
- Toward the array it offers a fill port (preload initial psums) and a drain port (stream finished psums out), each with valid/ready.
- A small command FSM sequences LOAD, COMP and DRAIN phases.

Parameters:
- DWd, 16 (PECfg::DWd): psum word width
- Depth, 16: number of psum entries
- AWd, $clog2(Depth): address width

Ports:
- i_clk  in  1  clock
- i_rst  in  1  synchronous reset, active-high
- i_cmd_valid  in  1  command strobe
- i_cmd  in  2  command: 0 LOAD, 1 COMP, 2 DRAIN, 3 reserved
- i_cmd_len  in  AWd+1  word count for LOAD/DRAIN, range 0..Depth
- o_busy  out  1  high when not IDLE
- i_comp_done  in  1  ends the COMP phase
- i_stall  in  1  PE pipeline stall
- i_rd_en  in  1  psum read request (SumStage first pixel)
- i_rd_addr  in  AWd  read address
- o_psum  out  DWd  read data, signed
- o_rd_valid  out  1  o_psum valid
- i_wr_en  in  1  psum write (SumStage last pixel)
- i_wr_addr  in  AWd  write address
- i_psum  in  DWd  write data, signed
- i_ld_valid / o_ld_ready / i_ld_data  in/out/in  1/1/DWd  fill stream
- o_dr_valid / i_dr_ready / o_dr_data  out/in/out  1/1/DWd  drain stream
- o_err  out  1  sticky protocol error

Behaviour:
Reset:
- State IDLE.
- All counters are 0.
- o_psum=0, o_rd_valid=0, o_ld_ready=0, o_dr_valid=0, o_dr_data=0, o_busy=0, o_err=0.
- Memory contents are not reset.

FSM states: IDLE, LOAD, COMP, DRAIN.
- Commands are accepted only in IDLE. i_cmd_valid in any other state, or i_cmd=3, is ignored and sets o_err.
- LOAD or DRAIN with len=0 visits the state for one cycle, then returns to IDLE.

LOAD:
- o_ld_ready=1 while ld_cnt<len.
- Each handshake (i_ld_valid&&o_ld_ready) writes mem[ld_cnt] and increments ld_cnt.
- After the handshake at ld_cnt=len-1: state goes to IDLE next cycle and o_ld_ready drops in that same next cycle.

COMP:
- Read latency is 1 cycle. If i_rd_en && !i_stall at cycle t, then o_psum=mem[i_rd_addr] and o_rd_valid=1 at t+1.
- o_rd_valid is a one-cycle pulse per accepted read.
- Write: i_wr_en && !i_stall writes mem[i_wr_addr]=i_psum at the clock edge.
- Read and write to the same address in the same cycle: bypass, so o_psum returns i_psum (the new value).
- i_stall=1: rd/wr enables are ignored; o_psum and o_rd_valid hold their values.
- i_comp_done: go to IDLE next cycle. A read accepted in the same cycle still produces its o_rd_valid pulse.
- i_rd_en or i_wr_en outside COMP is ignored and sets o_err.

DRAIN:
- Output register model.
- rd_cnt counts words fetched. The register loads mem[rd_cnt] when (!o_dr_valid || i_dr_ready) && rd_cnt<len.
- o_dr_valid rises 1 cycle after entry.
- While i_dr_ready=0: o_dr_valid and o_dr_data hold stable.
- Sustained throughput is 1 word/cycle when i_dr_ready=1.
- After the handshake of the len-th word: o_dr_valid=0 and state goes to IDLE.

Counters and addresses:
- Counters are AWd+1 bits wide, with no wrap-around inside a phase.
- A len>Depth is clamped to Depth and sets o_err.

Reset mid-phase:
- Aborts immediately to the reset values above.
- Any partial drain is discarded.

Arithmetic: no arithmetic on data; words are stored bit-exact as signed DWd.

Test Plan:
1. LOAD len=4 with data 0x0010, 0xFFF0, 0x7FFF, 0x8000, then DRAIN len=4 with i_dr_ready tied 1 -> o_dr_data sequence matches exactly, 1 word/cycle, o_busy falls after the 4th handshake.
2. COMP: write addr3=0x1234, then read addr3 the next cycle -> o_psum=0x1234, o_rd_valid 1 cycle later. Same-cycle write 0x5555 and read on addr5 -> o_psum=0x5555.
3. COMP with i_stall=1 during rd_en/wr_en on addr2 -> mem[2] unchanged, o_psum/o_rd_valid held. Deassert stall -> access takes effect.
4. DRAIN len=3 with i_dr_ready toggling 1,0,0,1,1 -> each word held stable while ready=0, no loss or duplication, 3 handshakes total.
5. i_cmd_valid during LOAD, i_rd_en in IDLE, len=20 with Depth=16 -> o_err=1 and stays 1. LOAD len=0 -> o_busy high for 1 cycle.
6. Assert i_rst in the middle of DRAIN after 2 of 4 words -> next cycle IDLE, o_dr_valid=0, o_err=0, and a new command is accepted.
